// File: rtl/dma_ch_arbiter_if.sv
// Channel-side request/grant bundle and AHB-side burst control for the DMA channel arbiter.
interface dma_ch_arbiter_if #(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned BLEN_W = 5
);
  localparam int unsigned SEL_W = $clog2(NUM_CH);

  logic [NUM_CH-1:0]        ch_req_i;
  logic [NUM_CH*BLEN_W-1:0] ch_len_i;
  logic [NUM_CH-1:0]        ch_gnt_o;
  logic [NUM_CH-1:0]        ch_done_o;
  logic [NUM_CH-1:0]        ch_err_o;
  logic [SEL_W-1:0]         ch_sel_o;
  logic                     if_start_o;
  logic [BLEN_W-1:0]        if_len_o;
  logic                     if_beat_i;
  logic                     if_err_i;
  logic                     busy_o;

  // Channels and the AHB master drive requests/beats; the arbiter drives grants/burst control.
  modport master (
    output ch_req_i, ch_len_i, if_beat_i, if_err_i,
    input  ch_gnt_o, ch_done_o, ch_err_o, ch_sel_o, if_start_o, if_len_o, busy_o
  );

  modport slave (
    input  ch_req_i, ch_len_i, if_beat_i, if_err_i,
    output ch_gnt_o, ch_done_o, ch_err_o, ch_sel_o, if_start_o, if_len_o, busy_o
  );
endinterface

// File: rtl/dma_ch_arbiter.sv
// Round-robin arbiter sharing one DMA AHB master between NUM_CH channels;
// grant is held for a whole burst and done/error status is pulsed back to the winner.
module dma_ch_arbiter #(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned BLEN_W = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  dma_ch_arbiter_if.slave bus
);

  localparam int unsigned SEL_W = $clog2(NUM_CH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    XFER  = 2'd2,
    DONE  = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic [SEL_W-1:0]    rr_q, rr_d;
  logic [SEL_W-1:0]    sel_q, sel_d;
  logic [BLEN_W-1:0]   cnt_q, cnt_d;
  logic [BLEN_W-1:0]   len_q, len_d;
  logic                err_q, err_d;
  logic [NUM_CH-1:0]   gnt_q, gnt_d;
  logic [NUM_CH-1:0]   done_q, done_d;
  logic [NUM_CH-1:0]   errp_q, errp_d;
  logic                start_q, start_d;
  logic                busy_q, busy_d;

  logic [SEL_W-1:0]    win;
  logic [BLEN_W-1:0]   win_len;
  logic [NUM_CH-1:0]   sel_oh;

  // First requester at or above ptr, wrapping; the lowest offset is visited last and wins.
  function automatic logic [SEL_W-1:0] rr_pick(input logic [NUM_CH-1:0] req,
                                               input logic [SEL_W-1:0]  ptr);
    logic [SEL_W-1:0] w;
    w = ptr;
    for (int i = int'(NUM_CH) - 1; i >= 0; i--) begin
      for (int k = 0; k < int'(NUM_CH); k++) begin
        if (req[k] && (k == (int'(ptr) + i) % int'(NUM_CH))) w = SEL_W'(k);
      end
    end
    return w;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      rr_q    <= '0;
      sel_q   <= '0;
      cnt_q   <= '0;
      len_q   <= '0;
      err_q   <= 1'b0;
      gnt_q   <= '0;
      done_q  <= '0;
      errp_q  <= '0;
      start_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      sel_q   <= sel_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      err_q   <= err_d;
      gnt_q   <= gnt_d;
      done_q  <= done_d;
      errp_q  <= errp_d;
      start_q <= start_d;
      busy_q  <= busy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    sel_d   = sel_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    err_d   = err_q;
    win     = rr_pick(bus.ch_req_i, rr_q);
    win_len = '0;
    for (int k = 0; k < int'(NUM_CH); k++) begin
      if (win == SEL_W'(k)) win_len = bus.ch_len_i[k*BLEN_W +: BLEN_W];
    end

    case (state_q)
      IDLE: begin
        if (|bus.ch_req_i) begin
          sel_d   = win;
          len_d   = win_len;
          cnt_d   = win_len;
          err_d   = 1'b0;
          state_d = ISSUE;
        end
      end
      ISSUE: state_d = XFER;
      XFER: begin
        // Error outranks the final beat so an aborted last beat still reports error.
        if (bus.if_err_i) begin
          err_d   = 1'b1;
          state_d = DONE;
        end else if (bus.if_beat_i) begin
          if (cnt_q == '0) state_d = DONE;
          else             cnt_d   = cnt_q - BLEN_W'(1);
        end
      end
      DONE: begin
        rr_d    = (sel_q == SEL_W'(NUM_CH - 1)) ? '0 : sel_q + SEL_W'(1);
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Outputs are registered from the next-state view so they line up with the state register.
    sel_oh = '0;
    for (int k = 0; k < int'(NUM_CH); k++) begin
      sel_oh[k] = (sel_d == SEL_W'(k));
    end
    gnt_d   = (state_d != IDLE) ? sel_oh : '0;
    done_d  = (state_d == DONE) ? sel_oh : '0;
    errp_d  = (state_d == DONE && err_d) ? sel_oh : '0;
    start_d = (state_d == ISSUE);
    busy_d  = (state_d != IDLE);
  end

  assign bus.ch_gnt_o   = gnt_q;
  assign bus.ch_done_o  = done_q;
  assign bus.ch_err_o   = errp_q;
  assign bus.ch_sel_o   = sel_q;
  assign bus.if_start_o = start_q;
  assign bus.if_len_o   = len_q;
  assign bus.busy_o     = busy_q;

endmodule

// File: tb/tb_dma_ch_arbiter.sv
// Randomized scoreboard bench for dma_ch_arbiter against a queue-based round-robin model.
module tb_dma_ch_arbiter;

  localparam int unsigned N  = 4;
  localparam int unsigned BW = 5;
  localparam int unsigned SW = $clog2(N);
  localparam int unsigned LW = N * BW;

  typedef struct {
    int sel;
    int len;
  } start_t;

  typedef struct {
    logic [N-1:0] done;
    logic [N-1:0] err;
  } done_t;

  logic clk;
  logic rst_n;

  dma_ch_arbiter_if #(.NUM_CH(N), .BLEN_W(BW)) bus ();

  dma_ch_arbiter #(.NUM_CH(N), .BLEN_W(BW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int     n_chk;
  int     n_fail;
  int     model_ptr;
  start_t sq[$];
  done_t  dq[$];

  function automatic void chk(string name, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, got, exp, $time);
    end
  endfunction

  function automatic logic [N-1:0] onehot(int i);
    return N'(1) << i;
  endfunction

  // Reference arbitration: scan channels starting at the pointer, wrapping around.
  function automatic int model_pick(logic [N-1:0] req);
    for (int o = 0; o < int'(N); o++) begin
      int c;
      c = (model_ptr + o) % int'(N);
      if (req[c]) return c;
    end
    return -1;
  endfunction

  // Scoreboard monitor: pop an expectation whenever the DUT presents a start or a done.
  always @(negedge clk) begin
    start_t s;
    done_t  d;
    if (rst_n) begin
      if (bus.if_start_o) begin
        if (sq.size() == 0) chk("unexpected_start", 32'd1, 32'd0);
        else begin
          s = sq.pop_front();
          chk("start_sel", 32'(bus.ch_sel_o), 32'(s.sel));
          chk("start_len", 32'(bus.if_len_o), 32'(s.len));
          chk("start_gnt", 32'(bus.ch_gnt_o), 32'(onehot(s.sel)));
        end
      end
      if (|bus.ch_done_o) begin
        if (dq.size() == 0) chk("unexpected_done", 32'(bus.ch_done_o), 32'd0);
        else begin
          d = dq.pop_front();
          chk("sb_done", 32'(bus.ch_done_o), 32'(d.done));
          chk("sb_err", 32'(bus.ch_err_o), 32'(d.err));
        end
      end else if (|bus.ch_err_o) begin
        chk("err_without_done", 32'(bus.ch_err_o), 32'd0);
      end
    end
  end

  task automatic check_all_zero(string tag);
    chk({tag, "_gnt"},   32'(bus.ch_gnt_o),   32'd0);
    chk({tag, "_done"},  32'(bus.ch_done_o),  32'd0);
    chk({tag, "_err"},   32'(bus.ch_err_o),   32'd0);
    chk({tag, "_sel"},   32'(bus.ch_sel_o),   32'd0);
    chk({tag, "_start"}, 32'(bus.if_start_o), 32'd0);
    chk({tag, "_len"},   32'(bus.if_len_o),   32'd0);
    chk({tag, "_busy"},  32'(bus.busy_o),     32'd0);
  endtask

  task automatic idle_gap(int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk("idle_busy", 32'(bus.busy_o), 32'd0);
      chk("idle_gnt", 32'(bus.ch_gnt_o), 32'd0);
      bus.ch_req_i  = '0;
      bus.if_beat_i = 1'($urandom_range(0, 1));
      bus.if_err_i  = 1'($urandom_range(0, 1));
    end
  endtask

  // One complete transaction; called right after a negedge, returns on the done-cycle negedge.
  task automatic run_xfer(input logic [N-1:0] req, input logic [LW-1:0] lens,
                          input int err_at, input bit err_with_beat, input bit issue_beat,
                          output int sel_seen, output int waited);
    int           w, len, beats, nb, cyc;
    bit           got, ended;
    logic [N-1:0] oh;
    w     = model_pick(req);
    len   = int'(lens[w*BW +: BW]);
    beats = len + 1;
    oh    = onehot(w);
    sq.push_back('{w, len});
    dq.push_back('{oh, (err_at > 0) ? oh : '0});
    model_ptr = (w + 1) % int'(N);

    bus.ch_req_i  = req;
    bus.ch_len_i  = lens;
    bus.if_beat_i = 1'b0;
    bus.if_err_i  = 1'b0;
    waited   = 0;
    got      = 1'b0;
    sel_seen = -1;
    while (!got && waited < 20) begin
      @(negedge clk);
      waited++;
      got = bus.if_start_o;
    end
    if (!got) begin
      chk("start_timeout", 32'd0, 32'd1);
      return;
    end
    sel_seen = int'(bus.ch_sel_o);

    // Issue cycle: beat/error and request/length changes must all be ignored.
    bus.if_beat_i = issue_beat;
    bus.if_err_i  = issue_beat & 1'($urandom_range(0, 1));
    bus.ch_req_i  = N'($urandom);
    bus.ch_len_i  = LW'($urandom);

    nb    = 0;
    ended = 1'b0;
    cyc   = 0;
    while (!ended && cyc < 300) begin
      @(negedge clk);
      cyc++;
      chk("xfer_no_done", 32'(bus.ch_done_o), 32'd0);
      chk("xfer_gnt", 32'(bus.ch_gnt_o), 32'(oh));
      chk("xfer_len", 32'(bus.if_len_o), 32'(len));
      chk("xfer_busy", 32'(bus.busy_o), 32'd1);
      bus.if_beat_i = 1'b0;
      bus.if_err_i  = 1'b0;
      if ($urandom_range(0, 3) == 0) begin
        // wait state on the bus
      end else if (err_at == nb + 1) begin
        bus.if_err_i  = 1'b1;
        bus.if_beat_i = err_with_beat;
        ended = 1'b1;
      end else begin
        bus.if_beat_i = 1'b1;
        nb++;
        if (nb == beats) ended = 1'b1;
      end
      if ($urandom_range(0, 7) == 0) bus.ch_req_i = N'($urandom);
    end
    if (!ended) chk("xfer_timeout", 32'd0, 32'd1);

    @(negedge clk);
    chk("done_pulse", 32'(bus.ch_done_o), 32'(oh));
    chk("done_err", 32'(bus.ch_err_o), (err_at > 0) ? 32'(oh) : 32'd0);
    chk("done_gnt", 32'(bus.ch_gnt_o), 32'(oh));
    chk("done_len", 32'(bus.if_len_o), 32'(len));
    chk("done_busy", 32'(bus.busy_o), 32'd1);
    bus.if_beat_i = 1'b0;
    bus.if_err_i  = 1'b0;
    bus.ch_req_i  = '0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [LW-1:0] lens;
    logic [N-1:0]  req;
    int            sel, wt, w, el, ea;
    logic [N-1:0]  rr_req [8];
    int            rr_exp [8];

    n_chk = 0;
    n_fail = 0;
    model_ptr = 0;
    rst_n = 1'b0;
    bus.ch_req_i  = '0;
    bus.ch_len_i  = '0;
    bus.if_beat_i = 1'b0;
    bus.if_err_i  = 1'b0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;

    // Reset mid-burst: ch1, len 3, two beats accepted, then asynchronous reset.
    lens = '0;
    lens[1*BW +: BW] = BW'(3);
    sq.push_back('{1, 3});
    bus.ch_req_i = N'(4'b0010);
    bus.ch_len_i = lens;
    wt = 0;
    while (!bus.if_start_o && wt < 20) begin
      @(negedge clk);
      wt++;
    end
    chk("rst_test_start", 32'(bus.if_start_o), 32'd1);
    @(negedge clk); bus.if_beat_i = 1'b1;
    @(negedge clk); bus.if_beat_i = 1'b1;
    @(negedge clk); bus.if_beat_i = 1'b0;
    chk("pre_rst_busy", 32'(bus.busy_o), 32'd1);
    #2 rst_n = 1'b0;
    #1 check_all_zero("async_rst");
    bus.ch_req_i = '0;
    model_ptr = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Round-robin order, including the pointer wrap with only ch0/ch2 requesting.
    rr_req = '{N'(4'hF), N'(4'hF), N'(4'hF), N'(4'hF), N'(4'h5), N'(4'h5), N'(4'hF), N'(4'hF)};
    rr_exp = '{0, 1, 2, 3, 0, 2, 3, 0};
    for (int i = 0; i < 8; i++) begin
      run_xfer(rr_req[i], '0, 0, 1'b0, 1'b0, sel, wt);
      chk("rr_order", 32'(sel), 32'(rr_exp[i]));
      if (i == 0) chk("start_latency", 32'(wt), 32'd1);
    end

    // Single 4-beat burst on ch2.
    lens = '0;
    lens[2*BW +: BW] = BW'(3);
    run_xfer(N'(4'b0100), lens, 0, 1'b0, 1'b0, sel, wt);
    chk("single_sel", 32'(sel), 32'd2);

    // Error abort on ch1: error with the 3rd beat, then with the last (8th) beat.
    lens = '0;
    lens[1*BW +: BW] = BW'(7);
    run_xfer(N'(4'b0010), lens, 3, 1'b1, 1'b0, sel, wt);
    run_xfer(N'(4'b0010), lens, 8, 1'b1, 1'b0, sel, wt);
    run_xfer(N'(4'b0010), lens, 5, 1'b0, 1'b0, sel, wt);

    // Beats in IDLE and ISSUE are ignored: a 2-beat burst still needs two XFER beats.
    idle_gap(3);
    lens = '0;
    lens[0*BW +: BW] = BW'(1);
    run_xfer(N'(4'b0001), lens, 0, 1'b0, 1'b1, sel, wt);
    chk("idle_start_latency", 32'(wt), 32'd1);

    // Maximum length burst on ch3.
    lens = '0;
    lens[3*BW +: BW] = BW'(31);
    run_xfer(N'(4'b1000), lens, 0, 1'b0, 1'b0, sel, wt);
    chk("maxlen_sel", 32'(sel), 32'd3);

    // Randomized traffic.
    for (int t = 0; t < 60; t++) begin
      req = N'($urandom_range(1, (1 << N) - 1));
      for (int c = 0; c < int'(N); c++) begin
        lens[c*BW +: BW] = ($urandom_range(0, 4) == 0) ? BW'(31) : BW'($urandom_range(0, 7));
      end
      w  = model_pick(req);
      el = int'(lens[w*BW +: BW]) + 1;
      ea = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, el)) : 0;
      run_xfer(req, lens, ea, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), sel, wt);
      chk("rand_sel", 32'(sel), 32'(w));
      if ($urandom_range(0, 3) == 0) idle_gap(int'($urandom_range(1, 3)));
    end

    idle_gap(4);
    chk("start_queue_empty", 32'(sq.size()), 32'd0);
    chk("done_queue_empty", 32'(dq.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/dma_ch_arbiter.md
Name: dma_ch_arbiter

Overview:
- Round-robin scheduler that shares the single DMA AHB master interface between NUM_CH DMA channels.
- Selects one requesting channel and issues a burst start with that channel's beat count to the AHB interface.
- Holds the grant until all beats complete or an error response arrives, then returns done or error status to the channel.
- Sits between the per-channel DMA engines and dma_ahb_if.

Parameters:
- NUM_CH, 4, number of requesting channels (2..8).
- BLEN_W, 5, width of burst length field. Burst beats = len+1, so 1..2^BLEN_W beats.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- ch_req_i  in  NUM_CH  per-channel transfer request (level).
- ch_len_i  in  NUM_CH*BLEN_W  per-channel beats-1. Channel k uses bits [k*BLEN_W +: BLEN_W].
- ch_gnt_o  out  NUM_CH  one-hot grant, held for the whole transfer.
- ch_done_o  out  NUM_CH  one-cycle pulse; the granted channel's transfer is finished.
- ch_err_o  out  NUM_CH  one-cycle pulse, coincident with ch_done_o; the transfer was aborted on error.
- ch_sel_o  out  $clog2(NUM_CH)  index of the granted channel (mux select for the address/data path).
- if_start_o  out  1  one-cycle burst start to dma_ahb_if.
- if_len_o  out  BLEN_W  latched beats-1 of the granted channel; stable from the start cycle until done.
- if_beat_i  in  1  one beat completed on AHB (data phase accepted).
- if_err_i  in  1  AHB error response on the current beat.
- busy_o  out  1  high in any state other than IDLE.

Behaviour:
- Clock/reset: one clock; reset is asynchronous and active-low.
- Reset values:
  - state = IDLE, rr_ptr = 0, counter = 0.
  - All outputs 0: ch_gnt_o, ch_done_o, ch_err_o, ch_sel_o, if_start_o, if_len_o, busy_o.
- FSM states: IDLE, ISSUE, XFER, DONE. All outputs are registered or decoded from registered state.
- IDLE:
  - ch_req_i is sampled only here.
  - If any request is set, pick the winner: the first set bit at or above rr_ptr, wrapping modulo NUM_CH.
  - Latch winner index into ch_sel_o and ch_len_i[winner] into if_len_o and the beat counter; go to ISSUE.
  - With no request, stay in IDLE.
- ISSUE (1 cycle):
  - ch_gnt_o = one-hot(ch_sel_o); if_start_o = 1; go to XFER.
  - if_beat_i and if_err_i are ignored in this cycle.
- XFER:
  - ch_gnt_o held.
  - On if_beat_i with counter != 0: decrement the counter.
  - On if_beat_i with counter == 0: go to DONE, ok.
  - On if_err_i (with or without if_beat_i): go to DONE, error. Error takes priority over the final beat.
- DONE (1 cycle):
  - ch_done_o[sel] = 1; ch_err_o[sel] = 1 if error; ch_gnt_o still held this cycle.
  - rr_ptr = (sel+1) mod NUM_CH; go to IDLE. ch_gnt_o drops in IDLE.
- Latency:
  - Request seen in IDLE at cycle t → if_start_o at t+1.
  - Final beat at cycle u → done pulse at u+1 → IDLE at u+2.
  - Minimum turnaround between consecutive grants: 3 cycles + beats.
- Request changes:
  - Deasserting ch_req_i during ISSUE/XFER/DONE has no effect; the transfer completes.
  - A new request or a length change is not seen until IDLE.
- A channel still requesting after its own done is rearbitrated with the lowest priority (rr_ptr has moved past it).
- if_beat_i or if_err_i while in IDLE or DONE: ignored, no state change.
- Reset mid-transfer:
  - Immediate return to reset values; no done pulse is generated.
  - dma_ahb_if is reset by the same rst_n.

Test Plan:
- Reset:
  - Stimulus: assert rst_n = 0 mid-XFER with ch1 granted and 2 beats left.
  - Response: all outputs 0 asynchronously; after release, IDLE with rr_ptr = 0; no ch_done_o pulse.
- Single burst:
  - Stimulus: ch_req_i = 4'b0100, ch_len[2] = 3.
  - Response: if_start_o 1 cycle later, if_len_o = 3, ch_sel_o = 2, ch_gnt_o = 4'b0100.
  - Response: ch_done_o = 4'b0100 exactly 1 cycle after the 4th if_beat_i; ch_err_o = 0.
- Round-robin:
  - Stimulus: ch_req_i = 4'b1111 held, all len = 0, one beat each.
  - Response: grant order 0, 1, 2, 3, 0.
  - Stimulus: after ch3 done, only ch2 and ch0 request.
  - Response: ch0 granted (pointer wrapped), then ch2.
- Error abort:
  - Stimulus: ch1 with len = 7; if_err_i on the 3rd beat together with if_beat_i.
  - Response: ch_done_o[1] and ch_err_o[1] pulse next cycle; no further beats counted.
  - Stimulus: repeat with if_err_i on the last beat.
  - Response: the error flag is still reported.
- Ignored inputs:
  - Stimulus: if_beat_i pulse in the ISSUE cycle and in IDLE.
  - Response: beat counter unchanged; a len = 1 burst still needs 2 XFER beats.
  - Stimulus: ch_req_i dropped mid-XFER.
  - Response: the transfer still completes with done.
- Max length:
  - Stimulus: len = 31 (32 beats) on ch3.
  - Response: done only after the 32nd beat; if_len_o stable at 31 from start through the DONE cycle; busy_o high throughout.
